// File: rtl/score_counter.sv
// Multi-channel bounded up/down score counter with edge-detected button levels, BCD digits and limit flags.
// Latency: cnt/evt 1 cycle after an input rise, digits 1 cycle behind cnt; no backpressure, every edge is taken.
module score_counter #(
    parameter int NCH     = 2,
    parameter int BW      = 7,
    parameter int MAX_VAL = 99,
    parameter int WRAP    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    up_i,
    input  logic [NCH-1:0]    down_i,
    input  logic              clear_i,
    output logic [NCH*BW-1:0] cnt_o,
    output logic [NCH*4-1:0]  tens_o,
    output logic [NCH*4-1:0]  ones_o,
    output logic [NCH-1:0]    at_max_o,
    output logic [NCH-1:0]    at_zero_o,
    output logic [NCH-1:0]    evt_o
);

    localparam logic [BW-1:0] MAX_V = BW'(MAX_VAL);

    logic [NCH-1:0] up_q;
    logic [NCH-1:0] down_q;
    logic [NCH-1:0] inc;
    logic [NCH-1:0] dec;
    logic [NCH-1:0] evt_d;
    logic [BW-1:0]  cnt_q [NCH];
    logic [BW-1:0]  cnt_d [NCH];
    logic [3:0]     tens_d [NCH];
    logic [3:0]     ones_d [NCH];

    // Subtract-10 chain; nine stages cover every value up to 99.
    function automatic logic [7:0] to_bcd(input logic [BW-1:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = 7'(v);
        t = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    always_comb begin
        inc = up_i & ~up_q;
        dec = down_i & ~down_q;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clear_i) begin
                cnt_d[c] = '0;
            end else if (inc[c] && !dec[c]) begin
                if (cnt_q[c] == MAX_V) begin
                    if (WRAP != 0) cnt_d[c] = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + BW'(1);
                end
            end else if (dec[c] && !inc[c]) begin
                if (cnt_q[c] == '0) begin
                    if (WRAP != 0) cnt_d[c] = MAX_V;
                end else begin
                    cnt_d[c] = cnt_q[c] - BW'(1);
                end
            end
            evt_d[c] = (cnt_d[c] != cnt_q[c]);
            {tens_d[c], ones_d[c]} = to_bcd(cnt_q[c]);
        end
    end

    always_comb begin
        cnt_o     = '0;
        at_max_o  = '0;
        at_zero_o = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_o[c*BW +: BW] = cnt_q[c];
            at_max_o[c]       = (cnt_q[c] == MAX_V);
            at_zero_o[c]      = (cnt_q[c] == '0);
        end
    end

    // Edge history loads even during reset so a held button cannot count on release.
    always_ff @(posedge clk_i) begin
        up_q   <= up_i;
        down_q <= down_i;
        if (!rst_i) begin
            for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
            evt_o  <= '0;
            tens_o <= '0;
            ones_o <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c]          <= cnt_d[c];
                tens_o[c*4 +: 4]  <= tens_d[c];
                ones_o[c*4 +: 4]  <= ones_d[c];
            end
            evt_o <= evt_d;
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: saturating and wrapping instances checked against a behavioural model through a queue.
// Directed scenarios follow the button sequences, then a random phase exercises both instances.
module tb_score_counter;

    localparam int NCH = 2;
    localparam int BW  = 7;
    localparam int MAXV = 99;

    logic clk;
    logic rst_n;
    logic clear;
    logic [NCH-1:0]    up_a, dn_a, up_b, dn_b;
    logic [NCH*BW-1:0] cnt_a, cnt_b;
    logic [NCH*4-1:0]  tens_a, ones_a, tens_b, ones_b;
    logic [NCH-1:0]    max_a, zero_a, evt_a, max_b, zero_b, evt_b;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int d;
        int c;
        int cnt;
        int evt;
        int tens;
        int ones;
    } exp_t;
    exp_t sb_q[$];

    int m_cnt [2][NCH];
    bit m_up  [2][NCH];
    bit m_dn  [2][NCH];

    score_counter #(.NCH(NCH), .BW(BW), .MAX_VAL(MAXV), .WRAP(0)) dut_sat (
        .clk_i(clk), .rst_i(rst_n), .up_i(up_a), .down_i(dn_a), .clear_i(clear),
        .cnt_o(cnt_a), .tens_o(tens_a), .ones_o(ones_a),
        .at_max_o(max_a), .at_zero_o(zero_a), .evt_o(evt_a)
    );

    score_counter #(.NCH(NCH), .BW(BW), .MAX_VAL(MAXV), .WRAP(1)) dut_wrap (
        .clk_i(clk), .rst_i(rst_n), .up_i(up_b), .down_i(dn_b), .clear_i(clear),
        .cnt_o(cnt_b), .tens_o(tens_b), .ones_o(ones_b),
        .at_max_o(max_b), .at_zero_o(zero_b), .evt_o(evt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int get_cnt(input int d, input int c);
        return (d == 0) ? int'(cnt_a[c*BW +: BW]) : int'(cnt_b[c*BW +: BW]);
    endfunction
    function automatic int get_tens(input int d, input int c);
        return (d == 0) ? int'(tens_a[c*4 +: 4]) : int'(tens_b[c*4 +: 4]);
    endfunction
    function automatic int get_ones(input int d, input int c);
        return (d == 0) ? int'(ones_a[c*4 +: 4]) : int'(ones_b[c*4 +: 4]);
    endfunction
    function automatic int get_bit(input logic [NCH-1:0] a, input logic [NCH-1:0] b,
                                   input int d, input int c);
        return (d == 0) ? int'(a[c]) : int'(b[c]);
    endfunction

    // Model the coming edge from the inputs now applied, push expectations, clock, then score.
    task automatic cycle();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                bit u, w, inc, dec;
                int old, nxt;
                u   = (d == 0) ? up_a[c] : up_b[c];
                w   = (d == 0) ? dn_a[c] : dn_b[c];
                inc = u && !m_up[d][c];
                dec = w && !m_dn[d][c];
                old = m_cnt[d][c];
                nxt = old;
                if (!rst_n || clear)
                    nxt = 0;
                else if (inc && !dec)
                    nxt = (d == 1) ? (old + 1) % (MAXV + 1) : ((old + 1 > MAXV) ? MAXV : old + 1);
                else if (dec && !inc)
                    nxt = (d == 1) ? (old + MAXV) % (MAXV + 1) : ((old == 0) ? 0 : old - 1);
                e.d    = d;
                e.c    = c;
                e.cnt  = nxt;
                e.evt  = (rst_n && nxt != old) ? 1 : 0;
                e.tens = rst_n ? old / 10 : 0;
                e.ones = rst_n ? old % 10 : 0;
                sb_q.push_back(e);
                m_cnt[d][c] = nxt;
                m_up[d][c]  = u;
                m_dn[d][c]  = w;
            end
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("cnt d%0d c%0d", e.d, e.c), get_cnt(e.d, e.c), e.cnt);
            check($sformatf("evt d%0d c%0d", e.d, e.c), get_bit(evt_a, evt_b, e.d, e.c), e.evt);
            check($sformatf("tens d%0d c%0d", e.d, e.c), get_tens(e.d, e.c), e.tens);
            check($sformatf("ones d%0d c%0d", e.d, e.c), get_ones(e.d, e.c), e.ones);
            check($sformatf("at_max d%0d c%0d", e.d, e.c), get_bit(max_a, max_b, e.d, e.c),
                  (e.cnt == MAXV) ? 1 : 0);
            check($sformatf("at_zero d%0d c%0d", e.d, e.c), get_bit(zero_a, zero_b, e.d, e.c),
                  (e.cnt == 0) ? 1 : 0);
        end
        @(negedge clk);
    endtask

    task automatic set_btn(input int d, input int c, input bit is_up, input bit v);
        if (d == 0) begin
            if (is_up) up_a[c] = v; else dn_a[c] = v;
        end else begin
            if (is_up) up_b[c] = v; else dn_b[c] = v;
        end
    endtask

    task automatic press(input int d, input int c, input bit is_up, input int n);
        for (int i = 0; i < n; i++) begin
            set_btn(d, c, is_up, 1'b1);
            cycle();
            set_btn(d, c, is_up, 1'b0);
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        up_a  = '0;
        dn_a  = '0;
        up_b  = '0;
        dn_b  = '0;
        up_a[0] = 1'b1;
        @(negedge clk);
        repeat (3) cycle();

        // Held button across reset release must not count.
        rst_n = 1'b1;
        repeat (2) cycle();
        check("hold_thru_reset cnt", get_cnt(0, 0), 0);
        check("hold_thru_reset evt", int'(evt_a[0]), 0);
        up_a[0] = 1'b0;
        cycle();
        up_a[0] = 1'b1;
        cycle();
        check("first_press cnt", get_cnt(0, 0), 1);
        check("first_press evt", int'(evt_a[0]), 1);
        up_a[0] = 1'b0;
        cycle();
        check("first_press tens", get_tens(0, 0), 0);
        check("first_press ones", get_ones(0, 0), 1);

        // Saturation at the top and bottom.
        press(0, 1, 1'b1, 101);
        check("sat_top cnt", get_cnt(0, 1), 99);
        check("sat_top at_max", int'(max_a[1]), 1);
        check("sat_top tens", get_tens(0, 1), 9);
        check("sat_top ones", get_ones(0, 1), 9);
        press(0, 1, 1'b0, 100);
        check("sat_bot cnt", get_cnt(0, 1), 0);
        check("sat_bot at_zero", int'(zero_a[1]), 1);

        // Wrap instance: 99 -> 0 and 0 -> 99.
        press(1, 0, 1'b1, 99);
        check("wrap_pre cnt", get_cnt(1, 0), 99);
        up_b[0] = 1'b1;
        cycle();
        check("wrap_up cnt", get_cnt(1, 0), 0);
        check("wrap_up evt", int'(evt_b[0]), 1);
        up_b[0] = 1'b0;
        cycle();
        dn_b[0] = 1'b1;
        cycle();
        check("wrap_dn cnt", get_cnt(1, 0), 99);
        check("wrap_dn evt", int'(evt_b[0]), 1);
        dn_b[0] = 1'b0;
        cycle();

        // Simultaneous up and down cancel; other channel independent.
        press(0, 0, 1'b1, 41);
        up_a = 2'b11;
        dn_a = 2'b01;
        cycle();
        check("both_edges cnt", get_cnt(0, 0), 42);
        check("both_edges evt", int'(evt_a[0]), 0);
        check("indep_ch1 cnt", get_cnt(0, 1), 1);
        check("indep_ch1 evt", int'(evt_a[1]), 1);
        up_a = '0;
        dn_a = '0;
        cycle();

        // Clear wins over a simultaneous up edge; the edge is consumed.
        press(0, 0, 1'b0, 5);
        press(0, 1, 1'b1, 11);
        check("pre_clear ch0", get_cnt(0, 0), 37);
        check("pre_clear ch1", get_cnt(0, 1), 12);
        clear   = 1'b1;
        up_a[0] = 1'b1;
        cycle();
        check("clear ch0 cnt", get_cnt(0, 0), 0);
        check("clear ch1 cnt", get_cnt(0, 1), 0);
        check("clear evt", int'(evt_a), 3);
        clear = 1'b0;
        cycle();
        check("post_clear cnt", get_cnt(0, 0), 0);
        check("post_clear tens", get_tens(0, 0), 0);
        check("post_clear ones", get_ones(0, 0), 0);
        up_a[0] = 1'b0;
        cycle();

        // Reset mid-count beats a pending down edge.
        press(0, 0, 1'b1, 55);
        check("pre_reset cnt", get_cnt(0, 0), 55);
        dn_a[0] = 1'b1;
        rst_n   = 1'b0;
        cycle();
        check("mid_reset cnt", get_cnt(0, 0), 0);
        check("mid_reset evt", int'(evt_a[0]), 0);
        check("mid_reset tens", get_tens(0, 0), 0);
        check("mid_reset ones", get_ones(0, 0), 0);
        rst_n   = 1'b1;
        dn_a[0] = 1'b0;
        cycle();

        for (int i = 0; i < 600; i++) begin
            up_a  = NCH'($urandom);
            dn_a  = NCH'($urandom);
            up_b  = NCH'($urandom);
            dn_b  = NCH'($urandom);
            clear = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
Multi-channel up/down score counter, the parametrised successor of the single-channel 0–99 counter on the scoreboard datapath. Each channel is a bounded counter driven by level inputs from the debounced push-buttons. Everything runs on one system clock, with internal rising-edge detection replacing the separate up/down clocks. Per channel it outputs the binary count, registered BCD tens/ones digits for the 7-segment driver, and limit flags.

Parameters:
NCH, 2, number of independent channels (teams); range 1–8
BW, 7, counter width per channel in bits; 2^BW-1 >= MAX_VAL
MAX_VAL, 99, upper count limit (inclusive); range 1–99 (BCD outputs cover two digits)
WRAP, 0, 0 = saturate at 0/MAX_VAL; 1 = wrap MAX_VAL+1 -> 0 and 0-1 -> MAX_VAL

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-low (rst_i=0 resets on next rising clk_i edge)
up_i  input  NCH  level request per channel; a rising edge increments by one
down_i  input  NCH  level request per channel; a rising edge decrements by one
clear_i  input  1  synchronous clear of all channels, active-high
cnt_o  output  NCH*BW  binary counts, channel c at bits [c*BW +: BW]
tens_o  output  NCH*4  BCD tens digit, channel c at [c*4 +: 4]
ones_o  output  NCH*4  BCD ones digit, channel c at [c*4 +: 4]
at_max_o  output  NCH  channel count == MAX_VAL (combinational from cnt)
at_zero_o  output  NCH  channel count == 0 (combinational from cnt)
evt_o  output  NCH  one-cycle pulse: channel count changed on this edge

Behaviour:
- Reset (rst_i=0 at clk edge):
  - cnt=0, tens=0, ones=0, evt=0.
  - up_q/down_q load current up_i/down_i, so a button held through reset release produces no count.
- Edge detection:
  - up_q/down_q register up_i/down_i every cycle.
  - inc[c] = up_i[c] & ~up_q[c]; dec[c] = down_i[c] & ~down_q[c].
  - A level held high counts once only.
- Count update at edge k uses inc/dec evaluated before edge k; the new cnt is visible after edge k (latency 1 from input rise).
- Priority per channel, highest first: rst_i=0 > clear_i > (inc & dec) > inc > dec > hold.
  - clear_i: cnt=0 for all channels; pending edges are consumed (up_q/down_q still update) and discarded.
  - inc & dec in the same cycle: no change, evt=0.
- inc with cnt==MAX_VAL: WRAP=0 holds at MAX_VAL with evt=0; WRAP=1 sets cnt=0 with evt=1.
- dec with cnt==0: WRAP=0 holds at 0 with evt=0; WRAP=1 sets cnt=MAX_VAL with evt=1.
- evt[c] = 1 for exactly the cycle after an edge at which cnt[c] changed value. clear_i from a nonzero count asserts evt; clear_i from 0 does not.
- BCD:
  - tens/ones are registered from the current cnt: tens = cnt/10, ones = cnt%10.
  - Digits lag cnt by one cycle.
  - Implement with combinational subtract-10 compare chain, no divider.
- Channels are fully independent except for the shared clear_i and rst_i.
- cnt never exceeds MAX_VAL in any mode.
- Mid-operation reset: takes effect on the next edge regardless of pending inc/dec; no count survives.

Test Plan:
1. Reset release with up_i[0]=1 held -> cnt_o ch0 stays 0, evt_o=0; releasing and re-pressing up_i[0] gives cnt=1 one cycle later, and tens/ones=0/1 one cycle after that.
2. WRAP=0, MAX_VAL=99: 101 up edges on ch1 -> cnt=99, at_max=1, tens/ones=9/9, evt=0 on edges 100 and 101. 100 down edges -> cnt=0, at_zero=1.
3. WRAP=1: from cnt=99, one up edge -> cnt=0 with evt=1. From 0, one down edge -> cnt=99 with evt=1.
4. up_i[0] and down_i[0] rise on the same cycle with cnt=42 -> cnt stays 42, evt=0. On the same cycle up_i[1] alone rises -> ch1 increments.
5. ch0=37, ch1=12, assert clear_i together with an up edge on ch0 -> both cnt=0 and both evt=1. The next cycle gives tens/ones=0/0, and the up edge is not counted.
6. rst_i=0 asserted mid-count with ch0=55 and a simultaneous down edge -> after that edge cnt=0, tens/ones=0, evt=0.
